// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//
// Multi-channel millisecond timer. A single free-running prescaler produces a
// one-cycle tick every CLK_PER_TICK clocks. On each tick, every running channel
// increments its counter. Each channel has the following:
//   - a compare register with a sticky match flag
//   - optional auto-reload to zero on match
//   - optional one-shot mode, where the channel pauses itself on match
// The controller issues one command per cycle to a single channel. Counts are
// read back combinationally through a channel-select mux.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cmd_en       in   command strobe, one command per asserted cycle
//   cmd_op       in   command opcode (NOP/PAUSE/CLEAR/SET_CMP/SET_MODE/ACK/LOAD)
//   cmd_ch       in   target channel of the command
//   cmd_data     in   command operand
//   rd_ch        in   channel whose count drives rd_count
//   rd_count     out  count of channel rd_ch (mux of registers)
//   match_flags  out  sticky per-channel compare-match flags
//   irq          out  OR of match_flags
//   tick         out  one-cycle pulse on each prescaler wrap
// -----------------------------------------------------------------------------
module timer_bank #(
   parameter int CH_W         = 2,
   parameter int COUNT_W      = 16,
   parameter int CLK_PER_TICK = 50000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_en,
   input  logic [2:0]             cmd_op,
   input  logic [CH_W-1:0]        cmd_ch,
   input  logic [COUNT_W-1:0]     cmd_data,
   input  logic [CH_W-1:0]        rd_ch,
   output logic [COUNT_W-1:0]     rd_count,
   output logic [(2**CH_W)-1:0]   match_flags,
   output logic                   irq,
   output logic                   tick
);

   localparam int NUM_CH = 2**CH_W;

   // Prescaler is sized for the largest legal CLK_PER_TICK (2**24).
   localparam int              PRE_W    = 24;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);

   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_PAUSE    = 3'd1;
   localparam logic [2:0] OP_CLEAR    = 3'd2;
   localparam logic [2:0] OP_SET_CMP  = 3'd3;
   localparam logic [2:0] OP_SET_MODE = 3'd4;
   localparam logic [2:0] OP_ACK      = 3'd5;
   localparam logic [2:0] OP_LOAD     = 3'd6;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PRE_W-1:0]   prescaler;

   logic [COUNT_W-1:0] count      [NUM_CH];
   logic [COUNT_W-1:0] cmp        [NUM_CH];
   logic [NUM_CH-1:0]  paused;
   logic [NUM_CH-1:0]  autoreload;
   logic [NUM_CH-1:0]  oneshot;

   // ---------------------------------------------------------------------------
   // Next-state and helper signals
   // ---------------------------------------------------------------------------
   logic [COUNT_W-1:0] count_nxt  [NUM_CH];
   logic [COUNT_W-1:0] cmp_nxt    [NUM_CH];
   logic [COUNT_W-1:0] incr       [NUM_CH];
   logic [NUM_CH-1:0]  paused_nxt;
   logic [NUM_CH-1:0]  autoreload_nxt;
   logic [NUM_CH-1:0]  oneshot_nxt;
   logic [NUM_CH-1:0]  flags_nxt;
   logic [NUM_CH-1:0]  sel;
   logic [NUM_CH-1:0]  step;
   logic [NUM_CH-1:0]  overwrite;
   logic [NUM_CH-1:0]  hit;

   logic op_pause;
   logic op_clear;
   logic op_set_cmp;
   logic op_set_mode;
   logic op_ack;
   logic op_load;

   // Prescaler: counts 0..CLK_PER_TICK-1. tick is registered from the wrap
   // condition, so it is high during the cycle in which the prescaler reads 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= {PRE_W{1'b0}};
         tick      <= 1'b0;
      end else begin
         if (prescaler == PRE_LAST) begin
            prescaler <= {PRE_W{1'b0}};
         end else begin
            prescaler <= prescaler + 24'd1;
         end
         tick <= (prescaler == PRE_LAST);
      end
   end

   // Opcode decode into one-hot strobes. NOP and the reserved code 7 decode to
   // no action.
   always_comb begin
      op_pause    = 1'b0;
      op_clear    = 1'b0;
      op_set_cmp  = 1'b0;
      op_set_mode = 1'b0;
      op_ack      = 1'b0;
      op_load     = 1'b0;
      case (cmd_op)
         OP_NOP:      op_pause    = 1'b0;
         OP_PAUSE:    op_pause    = 1'b1;
         OP_CLEAR:    op_clear    = 1'b1;
         OP_SET_CMP:  op_set_cmp  = 1'b1;
         OP_SET_MODE: op_set_mode = 1'b1;
         OP_ACK:      op_ack      = 1'b1;
         OP_LOAD:     op_load     = 1'b1;
         default:     op_pause    = 1'b0;
      endcase
   end

   // Per-channel next state. Every decision reads only the current
   // registers, never the command's new values. This is why a PAUSE still
   // sees the old paused bit, and a SET_CMP still compares against the old cmp.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sel[i]       = cmd_en && (cmd_ch == CH_W'(i));
         step[i]      = tick && !paused[i];
         incr[i]      = count[i] + COUNT_W'(1);
         // A CLEAR or LOAD replaces the increment, so no match is evaluated.
         overwrite[i] = sel[i] && (op_clear || op_load);
         hit[i]       = step[i] && !overwrite[i] && (incr[i] == cmp[i]);

         // Count: a command write takes priority over the tick increment.
         if (sel[i] && op_clear) begin
            count_nxt[i] = {COUNT_W{1'b0}};
         end else if (sel[i] && op_load) begin
            count_nxt[i] = cmd_data;
         end else if (step[i]) begin
            if (hit[i] && autoreload[i]) begin
               count_nxt[i] = {COUNT_W{1'b0}};
            end else begin
               count_nxt[i] = incr[i];
            end
         end else begin
            count_nxt[i] = count[i];
         end

         // Paused: an explicit PAUSE command overrides the one-shot
         // auto-pause.
         if (sel[i] && op_pause) begin
            paused_nxt[i] = cmd_data[0];
         end else if (hit[i] && oneshot[i]) begin
            paused_nxt[i] = 1'b1;
         end else begin
            paused_nxt[i] = paused[i];
         end

         if (sel[i] && op_set_cmp) begin
            cmp_nxt[i] = cmd_data;
         end else begin
            cmp_nxt[i] = cmp[i];
         end

         if (sel[i] && op_set_mode) begin
            autoreload_nxt[i] = cmd_data[0];
            oneshot_nxt[i]    = cmd_data[1];
         end else begin
            autoreload_nxt[i] = autoreload[i];
            oneshot_nxt[i]    = oneshot[i];
         end

         // Flag: a new match outranks an ACK in the same cycle, so no event
         // is lost.
         if (hit[i]) begin
            flags_nxt[i] = 1'b1;
         end else if (sel[i] && op_ack) begin
            flags_nxt[i] = 1'b0;
         end else begin
            flags_nxt[i] = match_flags[i];
         end
      end
   end

   // Channel registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            count[i] <= {COUNT_W{1'b0}};
            cmp[i]   <= {COUNT_W{1'b1}};
         end
         paused      <= {NUM_CH{1'b0}};
         autoreload  <= {NUM_CH{1'b0}};
         oneshot     <= {NUM_CH{1'b0}};
         match_flags <= {NUM_CH{1'b0}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            count[i] <= count_nxt[i];
            cmp[i]   <= cmp_nxt[i];
         end
         paused      <= paused_nxt;
         autoreload  <= autoreload_nxt;
         oneshot     <= oneshot_nxt;
         match_flags <= flags_nxt;
      end
   end

   // Read-back mux and interrupt. Both are driven directly from registers,
   // so an asynchronous reset clears them immediately.
   assign rd_count = count[rd_ch];
   assign irq      = |match_flags;

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
//
// Two instances of timer_bank are tested:
//   - u_dut4 (CLK_PER_TICK=4) checks prescaler pacing.
//   - u_dut1 (CLK_PER_TICK=1) ticks on every cycle, so each vector row equals
//     exactly one tick.
//
// The table vectors carry hand-computed counts and flags. Hand-written
// sequences cover the following:
//   - reset pacing
//   - the combinational read-back
//   - an asynchronous reset that arrives in the middle of a cycle
// -----------------------------------------------------------------------------
module tb_timer_bank;

   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_PAUSE    = 3'd1;
   localparam logic [2:0] OP_CLEAR    = 3'd2;
   localparam logic [2:0] OP_SET_CMP  = 3'd3;
   localparam logic [2:0] OP_SET_MODE = 3'd4;
   localparam logic [2:0] OP_ACK      = 3'd5;
   localparam logic [2:0] OP_LOAD     = 3'd6;
   localparam logic [2:0] OP_RSVD     = 3'd7;

   typedef struct {
      logic        en;
      logic [2:0]  op;
      logic [1:0]  ch;
      logic [15:0] data;
      logic [1:0]  rd;
      logic [15:0] exp_cnt;
      logic [3:0]  exp_flags;
   } vec_t;

   logic        clk;
   logic        reset_n;

   logic        cmd_en4, cmd_en1;
   logic [2:0]  cmd_op4, cmd_op1;
   logic [1:0]  cmd_ch4, cmd_ch1;
   logic [15:0] cmd_data4, cmd_data1;
   logic [1:0]  rd_ch4, rd_ch1;
   logic [15:0] rd_count4, rd_count1;
   logic [3:0]  flags4, flags1;
   logic        irq4, irq1;
   logic        tick4, tick1;

   int checks;
   int failures;

   vec_t vecs[$];

   timer_bank #(.CH_W(2), .COUNT_W(16), .CLK_PER_TICK(4)) u_dut4 (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_en      (cmd_en4),
      .cmd_op      (cmd_op4),
      .cmd_ch      (cmd_ch4),
      .cmd_data    (cmd_data4),
      .rd_ch       (rd_ch4),
      .rd_count    (rd_count4),
      .match_flags (flags4),
      .irq         (irq4),
      .tick        (tick4)
   );

   timer_bank #(.CH_W(2), .COUNT_W(16), .CLK_PER_TICK(1)) u_dut1 (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_en      (cmd_en1),
      .cmd_op      (cmd_op1),
      .cmd_ch      (cmd_ch1),
      .cmd_data    (cmd_data1),
      .rd_ch       (rd_ch1),
      .rd_count    (rd_count1),
      .match_flags (flags1),
      .irq         (irq1),
      .tick        (tick1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic en, input logic [2:0] op, input logic [1:0] ch,
                               input logic [15:0] data, input logic [1:0] rd,
                               input logic [15:0] cnt, input logic [3:0] fl);
      vec_t v;
      v.en = en; v.op = op; v.ch = ch; v.data = data;
      v.rd = rd; v.exp_cnt = cnt; v.exp_flags = fl;
      return v;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;

      // Row j is applied at edge j+1 after reset release. On u_dut1, that
      // edge increments each running channel from j >= 1 onwards.
      // Pause every channel first.
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd0, 16'd1,      2'd0, 16'd0,      4'h0)); // j0
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd2, 16'd1,      2'd2, 16'd1,      4'h0)); // pause on tick still increments
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd3, 16'd1,      2'd2, 16'd1,      4'h0)); // ...then holds
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd1, 16'd1,      2'd1, 16'd3,      4'h0));
      // ch1: cmp 5, auto-reload
      vecs.push_back(mk(1'b1, OP_SET_CMP,  2'd1, 16'd5,      2'd3, 16'd2,      4'h0)); // j4
      vecs.push_back(mk(1'b1, OP_SET_MODE, 2'd1, 16'd1,      2'd0, 16'd0,      4'h0));
      vecs.push_back(mk(1'b1, OP_CLEAR,    2'd1, 16'd0,      2'd1, 16'd0,      4'h0));
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd1, 16'd0,      2'd1, 16'd0,      4'h0)); // old paused=1: no inc
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd1,      4'h0)); // j8
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd2,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd3,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd4,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd0,      4'h2)); // j12 match, reload
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd1,      4'h2));
      vecs.push_back(mk(1'b1, OP_ACK,      2'd1, 16'd0,      2'd1, 16'd2,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd3,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd4,      4'h0)); // j16
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd0,      4'h2)); // re-set on wrap
      vecs.push_back(mk(1'b1, OP_ACK,      2'd1, 16'd0,      2'd1, 16'd1,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd2,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd3,      4'h0)); // j20
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd4,      4'h0));
      vecs.push_back(mk(1'b1, OP_ACK,      2'd1, 16'd0,      2'd1, 16'd0,      4'h2)); // ACK vs match: set wins
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd1, 16'd1,      2'd1, 16'd1,      4'h2));
      vecs.push_back(mk(1'b1, OP_ACK,      2'd1, 16'd0,      2'd1, 16'd1,      4'h0)); // j24
      // ch2: cmp 3, one-shot
      vecs.push_back(mk(1'b1, OP_SET_CMP,  2'd2, 16'd3,      2'd2, 16'd1,      4'h0));
      vecs.push_back(mk(1'b1, OP_SET_MODE, 2'd2, 16'd2,      2'd2, 16'd1,      4'h0));
      vecs.push_back(mk(1'b1, OP_CLEAR,    2'd2, 16'd0,      2'd2, 16'd0,      4'h0));
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd2, 16'd0,      2'd2, 16'd0,      4'h0)); // j28
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd2, 16'd1,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd2, 16'd2,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd2, 16'd3,      4'h4)); // match, auto-pause
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd2, 16'd3,      4'h4)); // j32
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd1, 16'd1,      4'h4));
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd2, 16'd0,      2'd2, 16'd3,      4'h4));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd2, 16'd4,      4'h4)); // resumes to 4
      vecs.push_back(mk(1'b1, OP_LOAD,     2'd2, 16'd1,      2'd2, 16'd1,      4'h4)); // j36 load beats inc
      vecs.push_back(mk(1'b1, OP_ACK,      2'd2, 16'd0,      2'd2, 16'd2,      4'h0));
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd2, 16'd0,      2'd2, 16'd3,      4'h4)); // PAUSE0 beats auto-pause
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd2, 16'd4,      4'h4));
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd2, 16'd1,      2'd2, 16'd5,      4'h4)); // j40
      vecs.push_back(mk(1'b1, OP_ACK,      2'd2, 16'd0,      2'd2, 16'd5,      4'h0));
      vecs.push_back(mk(1'b1, OP_LOAD,     2'd2, 16'd3,      2'd2, 16'd3,      4'h0)); // load == cmp: no flag
      vecs.push_back(mk(1'b1, OP_RSVD,     2'd2, 16'h1234,   2'd2, 16'd3,      4'h0)); // reserved = NOP
      // ch0: wrap and CLEAR/SET_CMP on a tick
      vecs.push_back(mk(1'b1, OP_SET_CMP,  2'd0, 16'h0010,   2'd0, 16'd0,      4'h0)); // j44
      vecs.push_back(mk(1'b1, OP_LOAD,     2'd0, 16'hFFFF,   2'd0, 16'hFFFF,   4'h0));
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd0, 16'd0,      2'd0, 16'hFFFF,   4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd0, 16'd0,      4'h0)); // silent wrap
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd0, 16'd1,      4'h0)); // j48
      vecs.push_back(mk(1'b1, OP_CLEAR,    2'd0, 16'd0,      2'd0, 16'd0,      4'h0)); // clear beats inc
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd0, 16'd1,      4'h0));
      vecs.push_back(mk(1'b1, OP_SET_CMP,  2'd0, 16'd2,      2'd0, 16'd2,      4'h0)); // old cmp used
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd0, 16'd3,      4'h0)); // j52
      // ch3: run up to 7 and match
      vecs.push_back(mk(1'b1, OP_SET_CMP,  2'd3, 16'd7,      2'd3, 16'd2,      4'h0));
      vecs.push_back(mk(1'b1, OP_LOAD,     2'd3, 16'd4,      2'd3, 16'd4,      4'h0));
      vecs.push_back(mk(1'b1, OP_PAUSE,    2'd3, 16'd0,      2'd3, 16'd4,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd3, 16'd5,      4'h0)); // j56
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd3, 16'd6,      4'h0));
      vecs.push_back(mk(1'b0, OP_NOP,      2'd0, 16'd0,      2'd3, 16'd7,      4'h8));

      reset_n   = 1'b0;
      cmd_en4   = 1'b0; cmd_op4 = OP_NOP; cmd_ch4 = 2'd0; cmd_data4 = 16'd0; rd_ch4 = 2'd0;
      cmd_en1   = 1'b0; cmd_op1 = OP_NOP; cmd_ch1 = 2'd0; cmd_data1 = 16'd0; rd_ch1 = 2'd0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst count4", rd_count4, 16'd0);
      check("rst flags4", flags4, 4'h0);
      check("rst irq4", irq4, 1'b0);
      check("rst tick4", tick4, 1'b0);
      check("rst count1", rd_count1, 16'd0);
      check("rst tick1", tick1, 1'b0);

      // Prescaler pacing: tick4 rises after every 4th edge, tick1 after every edge.
      reset_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("tick4 edge%0d", k), tick4, ((k % 4) == 0) ? 1'b1 : 1'b0);
         check($sformatf("tick1 edge%0d", k), tick1, 1'b1);
      end
      // The third tick was consumed on edge 13, so every channel now reads 3.
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
         rd_ch4 = c[1:0];
         #1;
         check($sformatf("count4 ch%0d after 3 ticks", c), rd_count4, 16'd3);
      end
      check("flags4 after 3 ticks", flags4, 4'h0);
      check("irq4 after 3 ticks", irq4, 1'b0);

      // Fresh reset for the command table on u_dut1.
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int j = 0; j < vecs.size(); j++) begin
         cmd_en1   = vecs[j].en;
         cmd_op1   = vecs[j].op;
         cmd_ch1   = vecs[j].ch;
         cmd_data1 = vecs[j].data;
         rd_ch1    = vecs[j].rd;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d count ch%0d", j, vecs[j].rd), rd_count1, vecs[j].exp_cnt);
         check($sformatf("vec%0d flags", j), flags1, vecs[j].exp_flags);
         check($sformatf("vec%0d irq", j), irq1, |vecs[j].exp_flags);
      end

      // The read mux follows rd_ch without waiting for a clock edge.
      cmd_en1 = 1'b0;
      cmd_op1 = OP_NOP;
      rd_ch1  = 2'd0;
      #1;
      check("rd mux ch0", rd_count1, 16'd9);
      rd_ch1 = 2'd3;
      #1;
      check("rd mux ch3", rd_count1, 16'd7);

      // Asynchronous reset mid-cycle: outputs clear before the next edge.
      reset_n = 1'b0;
      #1;
      check("async rst count ch3", rd_count1, 16'd0);
      check("async rst flags", flags1, 4'h0);
      check("async rst irq", irq1, 1'b0);
      check("async rst tick1", tick1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
